io_arbiter: RTL
===============

# io_arbiter

Two-master arbiter and bus sequencer for the 16-bit I/O bus. It lets the j1 CPU and a second requester, the USB endpoint DMA engine, share the I/O slave side (SIE registers, board I/O). It grants one master at a time using round-robin order and drives a single read or write strobe to the slaves. It holds the strobe until the slave signals `io_ready`, then returns the read data to the granted master with a one-cycle acknowledge. A bounded timeout keeps a silent slave from hanging the bus.

## Interface
- `TIMEOUT`, 64: maximum cycles in ISSUE without `io_ready` before the access is aborted; legal range 1..65535.
- `TIMEOUT_DATA`, 16'hDEAD: read data returned on an aborted access.

- `clk`  in  1  system clock; every register is clocked on the rising edge.
- `reset_n`  in  1  reset; synchronous and active-low.
- `m_rd`  in  2  read request, one bit per master.
- `m_wr`  in  2  write request, one bit per master.
- `m_addr`  in  2x16  address, one per master.
- `m_wdata`  in  2x16  write data, one per master.
- `m_ack`  out  2  one-cycle completion pulse to the granted master.
- `m_rdata`  out  16  read data; valid only while the matching `m_ack` bit is 1.
- `io_rd`  out  1  slave read strobe.
- `io_wr`  out  1  slave write strobe.
- `io_addr`  out  16  slave address.
- `io_dout`  out  16  slave write data.
- `io_din`  in  16  slave read data.
- `io_ready`  in  1  slave completion; the slave performs the access in the cycle it asserts this.
- `owner`  out  1  index of the master currently or last granted.
- `timeout_err`  out  1  sticky flag, set when an access is aborted.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- Master protocol:
  - The master asserts `m_rd` or `m_wr` and holds `m_addr` and `m_wdata` stable until it sees its `m_ack` bit.
  - A request still asserted in the cycle after the ack counts as a new request.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - A master is requesting when `m_rd|m_wr` is nonzero for it.
  - One master requesting: that master is granted.
  - Both requesting: the master that is not `owner` is granted.
  - On a grant, the granted master's address, data and operation are latched and the state moves to ISSUE.
  - If a master asserts both `m_rd` and `m_wr`, the read is performed and the write is ignored.
- ISSUE:
  - `io_rd` or `io_wr`, `io_addr` and `io_dout` are driven from the latched values.
  - `io_ready`=1: `io_din` is captured (reads only) and the state moves to RESP.
  - Otherwise the wait counter increments. When it reaches `TIMEOUT`, the strobes drop, `TIMEOUT_DATA` is captured, `timeout_err` is set and the state moves to RESP.
- RESP:
  - `m_ack[owner]`=1 and `m_rdata` carries the captured data.
  - The state moves to IDLE; no request is sampled in this cycle.
- `m_rdata` after a write ack is 16'h0000.
- `timeout_err`:
  - Cleared by `err_clr`.
  - When set and clear happen in the same cycle, set wins.
- Reset values:
  - State IDLE.
  - `io_rd`, `io_wr` and `m_ack` are 0.
  - `io_addr`, `io_dout` and `m_rdata` are 16'h0000.
  - `owner` is 1, so master 0 wins the first tie.
  - `timeout_err` is 0 and the wait counter is 0.
- Reset mid-access: at the first clock edge with `reset_n`=0, the state returns to IDLE, the strobes drop and no `m_ack` is issued.

## Timing
- All outputs are registered.
- Best-case latency with `io_ready` in the first ISSUE cycle:
  - request visible in cycle 0 (IDLE);
  - strobe in cycle 1;
  - `m_ack` in cycle 2;
  - next grant possible in cycle 3 (IDLE in cycle 3, strobe in cycle 4).
- Back-to-back throughput: one access per 3 cycles.
- A strobe is held for N+1 cycles when the slave asserts `io_ready` after N wait cycles.
- On timeout, the strobe is high for exactly `TIMEOUT` cycles and `m_ack` follows one cycle later.
- Wait counter:
  - width is $clog2(TIMEOUT+1);
  - cleared on entry to ISSUE;
  - does not wrap.

## Structure
- Add to package `types`:
  - `arb_state_t` enum (IDLE, ISSUE, RESP);
  - `io_op_t` enum (OP_RD, OP_WR);
  - constant `N_IO_MASTERS`=2.
- One sub-module is natural: `rr_pick2`, holding the `owner` register and the tie-break grant logic.
- The timeout counter stays inline in `io_arbiter`.

## Test plan
- Single read: master 0 reads 16'h0010 and the slave returns 16'h1234 with `io_ready` in the first ISSUE cycle. Required: `io_rd` in cycle 1, `m_ack`=2'b01 and `m_rdata`=16'h1234 in cycle 2.
- Contention: both masters request in the same cycle, starting from reset. Required: master 0 is granted first, master 1 next. With both holding requests, grants alternate 0,1,0,1.
- Wait states: write 16'hBEEF to 16'h0020 with `io_ready` arriving after 5 wait cycles. Required: `io_wr` is high for 6 cycles, `io_dout`=16'hBEEF throughout, ack follows one cycle later.
- Timeout: `TIMEOUT`=4 and `io_ready` is never asserted. Required: the strobe is high 4 cycles, `m_rdata`=16'hDEAD, `timeout_err`=1. Then `err_clr` pulses while a second timeout occurs in the same cycle: `timeout_err` stays 1.
- Reset mid-ISSUE: `reset_n`=0 in the third wait cycle. Required: at the next edge all outputs are at reset values, no `m_ack` pulse, and `owner`=1.
- Read/write conflict: master 1 asserts both `m_rd` and `m_wr`. Required: only `io_rd` pulses and the ack returns `io_din`.

Source files
------------

// File: rtl/io_arbiter_pkg.sv
// ============================================================================
// types : shared enums and constants for the I/O bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package types;

  localparam int N_IO_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } io_op_t;

endpackage

`default_nettype wire

// File: rtl/io_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : two-way round-robin pick; owner register plus tie-break grant
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2
  import types::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_IO_MASTERS-1:0] req_i,
  input  logic                    en_i,
  output logic                    gnt_valid_o,
  output logic                    gnt_idx_o,
  output logic                    owner_o
);

  logic owner_q;
  logic owner_d;
  logic gnt_idx;

  // On a tie the master that is not the current owner wins.
  always_comb begin
    gnt_idx = owner_q;
    case (req_i)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~owner_q;
      default: gnt_idx = owner_q;
    endcase
    owner_d = (en_i && (|req_i)) ? gnt_idx : owner_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q <= 1'b1;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign gnt_valid_o = |req_i;
  assign gnt_idx_o   = gnt_idx;
  assign owner_o     = owner_q;

endmodule

`default_nettype wire

// File: rtl/io_arbiter.sv
// ============================================================================
// io_arbiter : two-master round-robin arbiter and strobe sequencer, I/O bus
// Rev 1.0
// ============================================================================
`default_nettype none

module io_arbiter
  import types::*;
#(
  parameter int          TIMEOUT      = 64,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_IO_MASTERS-1:0]       m_rd,
  input  logic [N_IO_MASTERS-1:0]       m_wr,
  input  logic [N_IO_MASTERS-1:0][15:0] m_addr,
  input  logic [N_IO_MASTERS-1:0][15:0] m_wdata,
  output logic [N_IO_MASTERS-1:0]       m_ack,
  output logic [15:0]                   m_rdata,
  output logic                          io_rd,
  output logic                          io_wr,
  output logic [15:0]                   io_addr,
  output logic [15:0]                   io_dout,
  input  logic [15:0]                   io_din,
  input  logic                          io_ready,
  output logic                          owner,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT);

  arb_state_t                  state_q;
  io_op_t                      op_q;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_d;
  logic                        io_rd_q;
  logic                        io_wr_q;
  logic [15:0]                 io_addr_q;
  logic [15:0]                 io_dout_q;
  logic [N_IO_MASTERS-1:0]     m_ack_q;
  logic [15:0]                 m_rdata_q;
  logic                        timeout_err_q;

  logic [N_IO_MASTERS-1:0]     req;
  logic                        gnt_valid;
  logic                        gnt_idx;

  assign req   = m_rd | m_wr;
  assign cnt_d = cnt_q + 1'b1;

  rr_pick2 u_pick (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req),
    .en_i        (state_q == IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .owner_o     (owner)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_q          <= OP_RD;
      cnt_q         <= '0;
      io_rd_q       <= 1'b0;
      io_wr_q       <= 1'b0;
      io_addr_q     <= 16'h0000;
      io_dout_q     <= 16'h0000;
      m_ack_q       <= '0;
      m_rdata_q     <= 16'h0000;
      timeout_err_q <= 1'b0;
    end else begin
      // Clear first so a same-cycle timeout below overrides it.
      if (err_clr) timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          m_ack_q <= '0;
          if (gnt_valid) begin
            // A read takes precedence when both strobes are requested.
            op_q      <= m_rd[gnt_idx] ? OP_RD : OP_WR;
            io_rd_q   <= m_rd[gnt_idx];
            io_wr_q   <= ~m_rd[gnt_idx];
            io_addr_q <= m_addr[gnt_idx];
            io_dout_q <= m_wdata[gnt_idx];
            cnt_q     <= '0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (io_ready) begin
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            m_rdata_q <= (op_q == OP_RD) ? io_din : 16'h0000;
            m_ack_q   <= owner ? 2'b10 : 2'b01;
            state_q   <= RESP;
          end else if (cnt_d == TMO_CNT) begin
            cnt_q         <= cnt_d;
            io_rd_q       <= 1'b0;
            io_wr_q       <= 1'b0;
            m_rdata_q     <= TIMEOUT_DATA;
            m_ack_q       <= owner ? 2'b10 : 2'b01;
            timeout_err_q <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          m_ack_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          io_rd_q <= 1'b0;
          io_wr_q <= 1'b0;
          m_ack_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io_rd       = io_rd_q;
  assign io_wr       = io_wr_q;
  assign io_addr     = io_addr_q;
  assign io_dout     = io_dout_q;
  assign m_ack       = m_ack_q;
  assign m_rdata     = m_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire
